// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states, memory geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional misalignment trap is enabled by MEM_ACCESS_MISALIGN_TRAP_EN.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DM_WORDS   = 32;
    localparam int DM_IDX_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_WRITE,
        ST_RESP
    } state_e;

    // A half needs addr[0]==0, a word (including size 11) needs addr[1:0]==0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF) begin
            mis = off[0];
        end else if (size[1]) begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Lane steering: extracts/extends a load lane from a memory word, or merges store data into it.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_bit;

    // Little-endian lane selection; halves only look at offset bit 1.
    always_comb begin
        byte_lane = word_i[7:0];
        case (offset_i)
            2'd1:    byte_lane = word_i[15:8];
            2'd2:    byte_lane = word_i[23:16];
            2'd3:    byte_lane = word_i[31:24];
            default: byte_lane = word_i[7:0];
        endcase
        half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Load path: sign- or zero-extend the selected lane; size 11 behaves as a word.
    always_comb begin
        sign_bit = 1'b0;
        load_o   = word_i;
        case (size_i)
            SZ_BYTE: begin
                sign_bit = byte_lane[7] & ~unsigned_i;
                load_o   = {{24{sign_bit}}, byte_lane};
            end
            SZ_HALF: begin
                sign_bit = half_lane[15] & ~unsigned_i;
                load_o   = {{16{sign_bit}}, half_lane};
            end
            default: load_o = word_i;
        endcase
    end

    // Store path: drop the low bits of the store data into the addressed lane of the old word.
    always_comb begin
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (offset_i)
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    2'd3:    merge_o[31:24] = wdata_i[7:0];
                    default: merge_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer to a word-wide, registered-read data memory; sub-word stores do read-modify-write.
// Latency: load 3, word store 2, byte/half store 4 cycles from accept to rsp_valid (trap: 1).
// Backpressure: req_ready only in IDLE, busy otherwise. MEM_ACCESS_MISALIGN_TRAP_EN enables misalignment aborts.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic              busy,
    output logic              dm_mem_write,
    output logic              dm_mem_read,
    output logic [DATA_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_write_data,
    input  logic [DATA_W-1:0] dm_result
);

    localparam int AW = IDX_W + DM_IDX_LSB;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wword_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] merge_word;
    logic              accept;
    logic              trap;
    logic              unused_addr_hi;

    // Byte addresses wrap inside the memory; the high address bits have no effect.
    assign unused_addr_hi = ^req_addr[DATA_W-1:AW];

    assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lane_align u_lane_align (
        .size_i     (size_q),
        .offset_i   (addr_q[1:0]),
        .unsigned_i (uns_q),
        .word_i     (dm_result),
        .wdata_i    (wdata_q),
        .load_o     (load_word),
        .merge_o    (merge_word)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: word stores skip the read, misaligned accesses go straight to the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (trap) begin
                        state_d = ST_RESP;
                    end else if (req_write && req_size[1]) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:    state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = write_q ? ST_WRITE : ST_RESP;
            ST_WRITE:   state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; strobes are mutually exclusive by construction.
    always_comb begin
        req_ready    = 1'b0;
        dm_mem_read  = 1'b0;
        dm_mem_write = 1'b0;
        rsp_valid    = 1'b0;
        case (state_q)
            ST_IDLE:  req_ready    = 1'b1;
            ST_READ:  dm_mem_read  = 1'b1;
            ST_WRITE: dm_mem_write = 1'b1;
            ST_RESP:  rsp_valid    = 1'b1;
            default:  req_ready    = 1'b0;
        endcase
    end

    assign busy          = !req_ready;
    assign dm_address    = {{(DATA_W-IDX_W){1'b0}}, addr_q[AW-1:DM_IDX_LSB]};
    assign dm_write_data = wword_q;
    assign rsp_rdata     = rdata_q;

    // Request latch, write-word build and response data; rdata only changes on entry to RESP.
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr[AW-1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                write_q <= req_write;
                wdata_q <= req_wdata;
                if (trap) begin
                    rdata_q <= '0;
                end else if (req_write && req_size[1]) begin
                    wword_q <= req_wdata;
                end
            end
            if (state_q == ST_CAPTURE) begin
                if (write_q) begin
                    wword_q <= merge_word;
                end else begin
                    rdata_q <= load_word;
                end
            end
            if (state_q == ST_WRITE) begin
                rdata_q <= '0;
            end
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic mis_q;

    // Misalignment flag, set by a trapped accept and cleared by any normal completion.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mis_q <= 1'b0;
        end else if (accept && trap) begin
            mis_q <= 1'b1;
        end else if ((state_q == ST_WRITE) || ((state_q == ST_CAPTURE) && !write_q)) begin
            mis_q <= 1'b0;
        end
    end

    assign rsp_misaligned = mis_q;
`else
    assign rsp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-wide registered-read memory model.
// Latency: checks strobe/response cycle offsets relative to the accept cycle.
// Backpressure: exercises held req_valid across a busy period.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        busy;
    logic        dm_mem_write;
    logic        dm_mem_read;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_result;

    mem_access_unit dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .busy           (busy),
        .dm_mem_write   (dm_mem_write),
        .dm_mem_read    (dm_mem_read),
        .dm_address     (dm_address),
        .dm_write_data  (dm_write_data),
        .dm_result      (dm_result)
    );

    always #5 clock = ~clock;

    // Memory model: registered read port, word i initialised to i.
    logic [31:0] mem [0:31];
    logic        init_mem = 1'b1;
    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= i;
        end else begin
            if (dm_mem_read)  dm_result <= mem[dm_address[4:0]];
            if (dm_mem_write) mem[dm_address[4:0]] <= dm_write_data;
        end
    end

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          rd_at, wr_at, rsp_at;
    logic [31:0] rd_idx, wr_idx, wr_word, rsp_dat;
    logic        rsp_mis;

    // Present one request, record event offsets (1 = cycle after accept), return in IDLE.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd);
        req_write = wr; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        rd_at = -1; wr_at = -1; rsp_at = -1;
        rd_idx = 0; wr_idx = 0; wr_word = 0; rsp_dat = 32'hDEAD_DEAD; rsp_mis = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            if (dm_mem_read && dm_mem_write) overlap++;
            if (dm_mem_read && rd_at < 0) begin rd_at = c; rd_idx = dm_address; end
            if (dm_mem_write) begin wr_at = c; wr_idx = dm_address; wr_word = dm_write_data; end
            if (rsp_valid) begin rsp_at = c; rsp_dat = rsp_rdata; rsp_mis = rsp_misaligned; break; end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
    endtask

    task automatic expect_load(input string tag, input logic [31:0] exp);
        check({tag, "_rd_at"}, rd_at, 1);
        check({tag, "_rsp_at"}, rsp_at, 3);
        check({tag, "_data"}, rsp_dat, exp);
        check({tag, "_mis"}, {31'b0, rsp_mis}, 0);
    endtask

    int          acc2, r1, r2, bad;
    logic [31:0] d1, d2;

    initial begin
        // Reset and idle state.
        repeat (3) @(posedge clock);
        #1;
        init_mem = 1'b0;
        check("rst_ready", {31'b0, req_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_strobes", {30'b0, dm_mem_read, dm_mem_write}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_mis", {31'b0, rsp_misaligned}, 0);
        check("rst_dm_addr", dm_address, 0);
        check("rst_dm_wdata", dm_write_data, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // lw 0x0C
        issue(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
        expect_load("lw0c", 32'h0000_0003);
        check("lw0c_idx", rd_idx, 3);
        check("lw0c_hold", rsp_rdata, 32'h0000_0003);

        // sb 0xAB -> 0x09 (upper store bits must be ignored)
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'h1234_56AB);
        check("sb_rd_at", rd_at, 1);
        check("sb_wr_at", wr_at, 3);
        check("sb_rsp_at", rsp_at, 4);
        check("sb_wword", wr_word, 32'h0000_AB02);
        check("sb_widx", wr_idx, 2);
        check("sb_rdata", rsp_dat, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0);
        expect_load("lw08", 32'h0000_AB02);

        // sh 0xF00D -> 0x12, then loads of the merged word
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hBEEF_F00D);
        check("sh_wr_at", wr_at, 3);
        check("sh_rsp_at", rsp_at, 4);
        check("sh_wword", wr_word, 32'hF00D_0004);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0);
        expect_load("lh12", 32'hFFFF_F00D);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0);
        expect_load("lhu12", 32'h0000_F00D);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
        expect_load("lb13", 32'hFFFF_FFF0);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
        expect_load("lbu13", 32'h0000_00F0);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
        expect_load("lb10", 32'h0000_0004);

        // Word store with address wrap (0x94 aliases 0x14), size 11 as word on read-back
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0094, 32'hCAFE_BABE);
        check("sw_rd_at", rd_at, -1);
        check("sw_wr_at", wr_at, 1);
        check("sw_rsp_at", rsp_at, 2);
        check("sw_widx", wr_idx, 5);
        check("sw_wword", wr_word, 32'hCAFE_BABE);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0014, 32'h0);
        expect_load("lw14", 32'hCAFE_BABE);

        // Misaligned word and half loads
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        check("lw05_rsp_at", rsp_at, 1);
        check("lw05_mis", {31'b0, rsp_mis}, 1);
        check("lw05_data", rsp_dat, 0);
        check("lw05_strobes", {rd_at[15:0], wr_at[15:0]}, 32'hFFFF_FFFF);
        check("lw05_mis_hold", {31'b0, rsp_misaligned}, 1);
`else
        expect_load("lw05", 32'h0000_0001);
`endif
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0013, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        check("lh13_rsp_at", rsp_at, 1);
        check("lh13_mis", {31'b0, rsp_mis}, 1);
        check("lh13_data", rsp_dat, 0);
`else
        expect_load("lh13", 32'hFFFF_F00D);
`endif
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);
        expect_load("lw14b", 32'hCAFE_BABE);

        // Reset while the sub-word store is in READ
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0000_0021; req_wdata = 32'h0000_0055; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("rstrd_in_read", {31'b0, dm_mem_read}, 1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check("rstrd_ready", {31'b0, req_ready}, 1);
        check("rstrd_busy", {31'b0, busy}, 0);
        check("rstrd_rdata", rsp_rdata, 0);
        check("rstrd_dm_wdata", dm_write_data, 0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (dm_mem_write || rsp_valid) bad++;
            @(posedge clock); #1;
        end
        check("rstrd_no_activity", bad, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
        expect_load("lw20", 32'h0000_0008);

        // Back-to-back loads with req_valid held high
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_000C; req_valid = 1'b1;
        @(posedge clock); #1;
        req_addr = 32'h0000_0008;
        acc2 = -1; r1 = -1; r2 = -1; d1 = 0; d2 = 0;
        for (int c = 1; c <= 10; c++) begin
            if (dm_mem_read && dm_mem_write) overlap++;
            if (rsp_valid) begin
                if (r1 < 0) begin r1 = c; d1 = rsp_rdata; end
                else begin r2 = c; d2 = rsp_rdata; end
            end
            if (req_ready && acc2 < 0) acc2 = c;
            @(posedge clock); #1;
            if (acc2 >= 0) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("b2b_rsp1_at", r1, 3);
        check("b2b_rsp1_data", d1, 32'h0000_0003);
        check("b2b_acc2_at", acc2, 4);
        check("b2b_rsp2_at", r2, 7);
        check("b2b_rsp2_data", d2, 32'h0000_AB02);

        check("strobe_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the execute stage and `data_memory`. Accepts one byte, halfword or word request per handshake and translates byte addresses to word indices. Runs read-modify-write sequences for sub-word stores, since `data_memory` is word-wide with a registered read port. Returns sign- or zero-extended load data to the writeback path and stalls the pipeline while busy.

## Interface
- `DATA_W`, 32, data width; must match `data_memory`.
- `IDX_W`, 5, word-index width; 32-word memory.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; transfer occurs when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle pulse when the request completes.
- `rsp_rdata`  out  32  extended load data; 0 for stores.
- `rsp_misaligned`  out  1  misaligned-abort flag, valid with `rsp_valid`.
- `busy`  out  1  `!req_ready`; pipeline stall.
- `dm_mem_write`, `dm_mem_read`  out  1 each  strobes to `data_memory`.
- `dm_address`  out  32  word index, `{27'b0, addr[6:2]}`.
- `dm_write_data`  out  32  full word to store.
- `dm_result`  in  32  `data_memory` read result, valid the cycle after `dm_mem_read`.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE → on accept, latch addr, size, unsigned, write and wdata:
  - load → READ;
  - word store → WRITE;
  - byte/half store → READ.
- READ: `dm_mem_read=1` → CAPTURE.
- CAPTURE: sample `dm_result`.
  - Load: extract lane, extend, register into `rsp_rdata` → RESP.
  - Store: merge lane into the sampled word, register as write word → WRITE.
- WRITE: `dm_mem_write=1`, `dm_write_data` = write word → RESP.
- RESP: `rsp_valid=1` → IDLE.
- Lanes are little-endian. Byte k occupies bits [8k+7:8k], k = `addr[1:0]`. Half h occupies bits [16h+15:16h], h = `addr[1]`.
- Sign extension copies bit 7 (byte) or bit 15 (half) of the extracted lane.
- Byte/half stores use only the low 8/16 bits of `req_wdata`. Upper bits are ignored.
- `addr[31:7]` is ignored, so addresses wrap modulo 128 bytes.
- `dm_mem_read` and `dm_mem_write` are never high together, and neither is high outside READ/WRITE.

## Timing
- Reset (`reset==0` at posedge) → next cycle: state IDLE, `req_ready=1`, `busy=0`. All other outputs are 0, including `rsp_valid`, `rsp_rdata`, `rsp_misaligned`, both strobes, `dm_address` and `dm_write_data`.
- Reset mid-operation aborts the request with no response. A write is issued only if WRITE was already reached before reset.
- Accept cycle = A. Latencies:
  - load: `rsp_valid` at A+3;
  - word store: `dm_mem_write` at A+1, `rsp_valid` at A+2;
  - byte/half store: READ A+1, WRITE A+3, `rsp_valid` A+4.
- `req_ready` returns high the cycle after RESP. Back-to-back loads therefore accept every 4 cycles.
- `rsp_rdata` and `rsp_misaligned` hold until the next RESP or reset.

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined:
  - Misalignment is a half with `addr[0]=1` or a word with `addr[1:0]!=0`.
  - A misaligned request goes IDLE → RESP with no strobes.
  - The response is `rsp_valid` at A+1 with `rsp_misaligned=1` and `rsp_rdata=0`.
- Undefined:
  - Offending low bits are ignored: half uses `addr[1]` only; word ignores `addr[1:0]`.
  - `rsp_misaligned` is tied to 0.

## Structure
- `mem_access_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state enum;
  - `DM_WORDS=32`;
  - `DM_IDX_LSB=2`.
- One combinational sub-module, `lane_align`. It provides load extract/extend and store merge, selected by size, offset and unsigned.

## Test plan
- After reset (memory word i = i), `lw 0x0C` → `dm_mem_read` at A+1, `rsp_rdata=0x00000003` at A+3.
- `sb 0xAB → 0x09`, then `lw 0x08` → write word `0x0000AB02` at A+3, then `rsp_rdata=0x0000AB02`.
- `sh 0xF00D → 0x12`, then `lh 0x12` → `0xFFFFF00D`; `lhu 0x12` → `0x0000F00D`; `lb 0x13` → `0xFFFFFFF0`.
- `lw 0x05`:
  - with macro: `rsp_valid` at A+1, `rsp_misaligned=1`, no strobes;
  - without: `rsp_rdata=0x00000001` at A+3.
- `reset` low during READ of `sb` → no `dm_mem_write`, no `rsp_valid`, `req_ready=1` in the cycle after release.
- `req_valid` held high with two `lw` → second accepted at A+4, second `rsp_valid` at A+7.
